// File: rtl/bsg_link_sdr_deser_phy.sv
// Receive-side SDR PHY: registers incoming phits, pairs low/high halves into
// full words, and buffers them in a small FIFO with a valid/ready output.
//
// state | meaning
// EVEN  | next valid phit is a low half
// ODD   | low half held in low_r, waiting for its high half
module bsg_link_sdr_deser_phy #(
    parameter int width_p = 16,
    parameter int els_p   = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   valid_i,
    input  logic [width_p-1:0]     data_i,
    output logic                   valid_o,
    output logic [2*width_p-1:0]   data_o,
    input  logic                   ready_i,
    output logic                   half_o,
    output logic                   overflow_o
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = ptr_w + 1;
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);

    typedef enum logic {EVEN = 1'b0, ODD = 1'b1} state_e;

    state_e state_r, state_n;

    logic               valid_r;
    logic [width_p-1:0] data_r;
    logic [width_p-1:0] low_r;
    logic               load_low;
    logic               push;
    logic               pop;
    logic               full;
    logic               wr_en;
    logic               drop;

    logic [ptr_w-1:0]     wr_ptr_r;
    logic [ptr_w-1:0]     rd_ptr_r;
    logic [cnt_w-1:0]     count_r;
    logic                 overflow_r;
    logic [2*width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_r <= 1'b0;
            state_r <= EVEN;
        end else begin
            valid_r <= valid_i;
            state_r <= state_n;
        end
    end

    // Data path carries no reset; valid_r and the FSM qualify everything.
    always_ff @(posedge clk_i) begin
        data_r <= data_i;
        if (load_low) begin
            low_r <= data_r;
        end
        if (wr_en) begin
            mem_r[wr_ptr_r] <= {data_r, low_r};
        end
    end

    always_comb begin
        state_n  = state_r;
        load_low = 1'b0;
        push     = 1'b0;
        case (state_r)
            EVEN: begin
                if (valid_r) begin
                    load_low = 1'b1;
                    state_n  = ODD;
                end
            end
            ODD: begin
                if (valid_r) begin
                    push    = 1'b1;
                    state_n = EVEN;
                end
            end
            default: state_n = EVEN;
        endcase
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO survives.
    assign full  = (count_r == full_cnt);
    assign pop   = valid_o & ready_i;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_r <= wr_ptr_r + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + ptr_w'(1);
            end
            count_r <= count_r + cnt_w'(wr_en) - cnt_w'(pop);
            if (drop) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign valid_o    = (count_r != '0);
    assign data_o     = mem_r[rd_ptr_r];
    assign half_o     = (state_r == ODD);
    assign overflow_o = overflow_r;

endmodule

// File: tb/tb_bsg_link_sdr_deser_phy.sv
// Directed bench for bsg_link_sdr_deser_phy: pairing, gaps, backpressure,
// overflow, full-with-pop, and asynchronous reset behaviour.
module tb_bsg_link_sdr_deser_phy;

    logic        clk_i;
    logic        reset_i;
    logic        valid_i;
    logic [15:0] data_i;
    logic        valid_o;
    logic [31:0] data_o;
    logic        ready_i;
    logic        half_o;
    logic        overflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    bsg_link_sdr_deser_phy #(.width_p(16), .els_p(2)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .ready_i    (ready_i),
        .half_o     (half_o),
        .overflow_o (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, let one edge capture them, return 1 time unit after it.
    task automatic drive(input logic v, input logic [15:0] d, input logic r);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_assert;
        #2;
        reset_i = 1'b1;
        #1;
    endtask

    task automatic reset_release;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_half", half_o, 0);
        check("rst_ovf", overflow_o, 0);
        reset_i = 1'b0;
        drive(0, 16'h0, 0);

        // back-to-back pairs
        drive(1, 16'h1111, 1);
        check("b2b_half0", half_o, 0);
        drive(1, 16'h2222, 1);
        check("b2b_half1", half_o, 1);
        check("b2b_novalid", valid_o, 0);
        drive(1, 16'h3333, 1);
        check("b2b_v1", valid_o, 1);
        check("b2b_w1", data_o, 32'h2222_1111);
        drive(1, 16'h4444, 1);
        check("b2b_empty", valid_o, 0);
        drive(0, 16'h0, 1);
        check("b2b_v2", valid_o, 1);
        check("b2b_w2", data_o, 32'h4444_3333);
        drive(0, 16'h0, 1);
        check("b2b_drained", valid_o, 0);
        check("b2b_ovf", overflow_o, 0);

        // gap mid-word
        drive(1, 16'hAAAA, 1);
        drive(0, 16'h0, 1);
        check("gap_half_a", half_o, 1);
        drive(0, 16'h0, 1);
        drive(0, 16'h0, 1);
        check("gap_half_b", half_o, 1);
        check("gap_novalid", valid_o, 0);
        drive(1, 16'hBBBB, 1);
        check("gap_half_c", half_o, 1);
        drive(0, 16'h0, 1);
        check("gap_v", valid_o, 1);
        check("gap_w", data_o, 32'hBBBB_AAAA);
        drive(0, 16'h0, 1);
        check("gap_single", valid_o, 0);

        // full FIFO with simultaneous pop on push
        drive(1, 16'h0010, 0);
        drive(1, 16'h0011, 0);
        drive(1, 16'h0012, 0);
        drive(1, 16'h0013, 0);
        drive(1, 16'h0014, 0);
        drive(1, 16'h0015, 0);
        check("fp_head", data_o, 32'h0011_0010);
        drive(0, 16'h0, 1);
        check("fp_ovf", overflow_o, 0);
        check("fp_w2", data_o, 32'h0013_0012);
        drive(0, 16'h0, 1);
        check("fp_v3", valid_o, 1);
        check("fp_w3", data_o, 32'h0015_0014);
        drive(0, 16'h0, 1);
        check("fp_empty", valid_o, 0);

        // backpressure and overflow
        for (int i = 1; i <= 6; i++) drive(1, 16'(i), 0);
        drive(0, 16'h0, 0);
        drive(0, 16'h0, 0);
        check("ov_flag", overflow_o, 1);
        check("ov_v", valid_o, 1);
        check("ov_w1", data_o, 32'h0002_0001);
        drive(0, 16'h0, 1);
        check("ov_w2", data_o, 32'h0004_0003);
        drive(0, 16'h0, 1);
        check("ov_empty", valid_o, 0);
        check("ov_sticky", overflow_o, 1);

        // reset with a full FIFO
        for (int i = 0; i < 4; i++) drive(1, 16'(16'h0021 + i), 0);
        drive(0, 16'h0, 0);
        check("rf_full_v", valid_o, 1);
        reset_assert();
        check("rf_valid", valid_o, 0);
        check("rf_ovf", overflow_o, 0);
        reset_release();
        drive(1, 16'h0031, 1);
        drive(1, 16'h0032, 1);
        drive(0, 16'h0, 1);
        check("rf_v", valid_o, 1);
        check("rf_w", data_o, 32'h0032_0031);
        drive(0, 16'h0, 1);

        // reset mid-word
        drive(1, 16'h1234, 1);
        drive(0, 16'h0, 1);
        check("rm_half1", half_o, 1);
        reset_assert();
        check("rm_half0", half_o, 0);
        check("rm_valid", valid_o, 0);
        reset_release();
        drive(1, 16'h5678, 1);
        drive(1, 16'h9ABC, 1);
        check("rm_nov", valid_o, 0);
        drive(0, 16'h0, 1);
        check("rm_v", valid_o, 1);
        check("rm_w", data_o, 32'h9ABC_5678);
        drive(0, 16'h0, 1);
        check("rm_empty", valid_o, 0);
        check("rm_half_end", half_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
